keypad_scan: RTL and testbench

- Input-direction companion to the multiplexed 7-segment driver: scans a 4x4 active-low key matrix on the PI4 header instead of driving digits.
- Drives one row low at a time and samples the columns. Debounces over whole-matrix snapshots.
- Queues newly pressed key codes in a small FIFO that the SoC reads through GPIO (valid/ack pop).
- Sits beside the 7-segment driver in top; outputs feed an io_pin GPIO bank.

---
 rtl/keypad_scan.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// 4x4 active-low key matrix scanner: row-by-row sampling, whole-matrix debounce,
// and a small FIFO of newly pressed key codes popped with valid/ack.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  row_out,
  input  logic [3:0]  col_in,
  output logic [15:0] key_state,
  output logic        key_valid,
  output logic [3:0]  key_code,
  input  logic        key_ack,
  output logic        overflow,
  input  logic        overflow_clr,
  output logic [1:0]  dbg_state
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_PUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      snap_q, snap_d;
  logic [15:0]      prev_q, prev_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic [15:0]      key_state_q, key_state_d;
  logic [15:0]      new_press_q, new_press_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       col_meta_q, col_meta_d;
  logic [3:0]       col_sync_q, col_sync_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [15:0] snap_full;
  logic        push, do_push, pop, full;

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    div_d       = div_q;
    snap_d      = snap_q;
    prev_d      = prev_q;
    stable_d    = stable_q;
    key_state_d = key_state_q;
    new_press_d = new_press_q;
    idx_d       = idx_q;
    col_meta_d  = col_in;
    col_sync_d  = col_meta_q;
    row_out     = 4'hF;
    push        = 1'b0;
    snap_full   = snap_q;
    snap_full[{row_q, 2'b00} +: 4] = ~col_sync_q;

    case (state_q)
      ST_IDLE: state_d = ST_SCAN;
      ST_SCAN: begin
        row_out = ~(4'b0001 << row_q);
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          snap_d = snap_full;
          row_d  = row_q + 2'd1;
          // Last row of the scan closes a full snapshot: run the debounce on it.
          if (row_q == 2'd3) begin
            prev_d = snap_full;
            if (snap_full == prev_q)
              stable_d = (stable_q == STB_MAX) ? stable_q : stable_q + STB_W'(1);
            else
              stable_d = STB_W'(1);
            if (stable_d == STB_MAX && snap_full != key_state_q) begin
              key_state_d = snap_full;
              new_press_d = snap_full & ~key_state_q;
              if ((snap_full & ~key_state_q) != 16'h0) begin
                state_d = ST_PUSH;
                idx_d   = 4'd0;
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_PUSH: begin
        push  = new_press_q[idx_q];
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = ST_SCAN;
          row_d   = 2'd0;
          div_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO: a pop frees a slot in the same cycle, so push+pop while full never drops.
  always_comb begin
    full       = (count_q == CNT_FULL);
    key_valid  = (count_q != '0);
    pop        = key_ack && key_valid;
    do_push    = push && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_clr ? 1'b0 : overflow_q;
    if (push && full && !pop) overflow_d = 1'b1;
    if (do_push) begin
      mem_d[wr_ptr_q] = idx_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign key_code  = key_valid ? mem_q[rd_ptr_q] : 4'h0;
  assign key_state = key_state_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      row_q       <= 2'd0;
      div_q       <= '0;
      snap_q      <= 16'h0;
      prev_q      <= 16'h0;
      stable_q    <= '0;
      key_state_q <= 16'h0;
      new_press_q <= 16'h0;
      idx_q       <= 4'd0;
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 4'h0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      div_q       <= div_d;
      snap_q      <= snap_d;
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      key_state_q <= key_state_d;
      new_press_q <= new_press_d;
      idx_q       <= idx_d;
      col_meta_q  <= col_meta_d;
      col_sync_q  <= col_sync_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix model drives col_in from row_out, and a
// scoreboard queue tracks the key codes the FIFO should present.
module tb_keypad_scan;

  localparam int SCAN_DIV       = 8;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int FIFO_DEPTH     = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  row_out;
  logic [3:0]  col_in;
  logic [15:0] key_state;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ack;
  logic        overflow;
  logic        overflow_clr;
  logic [1:0]  dbg_state;

  logic [15:0] pressed;
  logic [15:0] model_state;
  logic        exp_ovf;
  logic [3:0]  exp_q[$];
  int          n_vec;
  int          n_err;

  keypad_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_out     (row_out),
    .col_in      (col_in),
    .key_state   (key_state),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ack     (key_ack),
    .overflow    (overflow),
    .overflow_clr(overflow_clr),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  // Pressed key {r,c} pulls column c low while row r is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_scan_start();
    logic [3:0] prev;
    bit         seen;
    prev = row_out;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (row_out == 4'b1110 && prev != 4'b1110) seen = 1'b1;
      prev = row_out;
    end
    if (!seen) chk("scan_start_timeout", 32'(seen), 32'(1));
  endtask

  // Present a new matrix at a scan start, hold it through acceptance and any PUSH.
  task automatic apply_map(input logic [15:0] map);
    logic [15:0] newp;
    wait_scan_start();
    pressed = map;
    wait_scan_start();
    wait_scan_start();
    repeat (32) @(negedge clk);
    newp = map & ~model_state;
    for (int i = 0; i < 16; i++)
      if (newp[i]) begin
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(4'(i));
        else exp_ovf = 1'b1;
      end
    model_state = map;
    chk("key_state", 32'(key_state), 32'(model_state));
    repeat (18) @(negedge clk);
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("key_valid", 32'(key_valid), 32'(exp_q.size() != 0));
  endtask

  task automatic drain_fifo();
    int         got;
    int         want;
    logic [3:0] e;
    got  = 0;
    want = exp_q.size();
    for (int k = 0; k < FIFO_DEPTH + 2; k++) begin
      if (!key_valid) break;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("key_code", 32'(key_code), 32'(e));
      end
      got++;
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
    end
    chk("drain_count", 32'(got), 32'(want));
    chk("drained_valid", 32'(key_valid), 32'(0));
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst          = 1'b1;
    key_ack      = 1'b0;
    overflow_clr = 1'b0;
    pressed      = 16'h0;
    model_state  = 16'h0;
    exp_ovf      = 1'b0;

    // reset state and idle row walk
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row_out", 32'(row_out), 32'hF);
    chk("rst_key_state", 32'(key_state), 32'(0));
    chk("rst_key_valid", 32'(key_valid), 32'(0));
    chk("rst_key_code", 32'(key_code), 32'(0));
    chk("rst_overflow", 32'(overflow), 32'(0));
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [3:0] exp_row;
      @(negedge clk);
      exp_row = ~(4'b0001 << (i / SCAN_DIV));
      chk("idle_row_out", 32'(row_out), 32'(exp_row));
    end
    chk("idle_key_state", 32'(key_state), 32'(0));
    chk("idle_key_valid", 32'(key_valid), 32'(0));

    // single key row2/col1, timed against the PUSH index walk
    wait_scan_start();
    pressed = 16'h0200;
    wait_scan_start();
    wait_scan_start();
    chk("ks_before_accept", 32'(key_state), 32'(0));
    repeat (32) @(negedge clk);
    chk("ks_accept", 32'(key_state), 32'h0200);
    chk("push_row_out", 32'(row_out), 32'hF);
    model_state = 16'h0200;
    exp_q.push_back(4'h9);
    repeat (9) @(negedge clk);
    chk("valid_before_i9", 32'(key_valid), 32'(0));
    @(negedge clk);
    chk("valid_after_i9", 32'(key_valid), 32'(1));
    drain_fifo();
    apply_map(16'h0000);

    // bounce: toggling every scan never settles
    for (int s = 0; s < 6; s++) begin
      wait_scan_start();
      pressed = (s % 2 == 0) ? 16'h0040 : 16'h0000;
    end
    wait_scan_start();
    chk("bounce_key_state", 32'(key_state), 32'(0));
    chk("bounce_key_valid", 32'(key_valid), 32'(0));
    apply_map(16'h0040);
    drain_fifo();
    apply_map(16'h0000);

    // two keys together, ascending queue order, then release
    apply_map(16'h1008);
    drain_fifo();
    apply_map(16'h0000);

    // five presses without ack: fifth is dropped
    apply_map(16'h0001);
    apply_map(16'h0000);
    apply_map(16'h0020);
    apply_map(16'h0000);
    apply_map(16'h0400);
    apply_map(16'h0000);
    apply_map(16'h8000);
    apply_map(16'h0000);
    apply_map(16'h0080);
    apply_map(16'h0000);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("overflow_clr", 32'(overflow), 32'(0));
    drain_fifo();

    // reset mid-row discards a pending code
    apply_map(16'h0004);
    wait_scan_start();
    repeat (11) @(negedge clk);
    chk("pre_rst_valid", 32'(key_valid), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_row_out", 32'(row_out), 32'hF);
    chk("midrst_key_valid", 32'(key_valid), 32'(0));
    chk("midrst_key_state", 32'(key_state), 32'(0));
    exp_q.delete();
    model_state = 16'h0;
    pressed = 16'h0;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_row_out", 32'(row_out), 32'hE);
    apply_map(16'h0000);
    drain_fifo();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
